// File: rtl/mesh_tx_pkg.sv
// Shared field offsets, watchdog states and destination check for the mesh transmit endpoint.
// Offsets are distances from the packet MSB end: bit index = pckg_sz - <offset>.
package mesh_tx_pkg;

    localparam int NXT_MSB     = 1;
    localparam int ROW_MSB     = 9;
    localparam int COL_MSB     = 13;
    localparam int MODE_BIT    = 17;
    localparam int PAYLOAD_MSB = 18;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALLED
    } tx_wd_state_e;

    // Terminals sit on the mesh border ring; corners and the interior are unreachable.
    function automatic logic is_legal_dst(
        input logic [3:0] row,
        input logic [3:0] col,
        input int         rows,
        input int         colums,
        input int         id_row,
        input int         id_column
    );
        int   r;
        int   c;
        logic on_row_edge;
        logic on_col_edge;
        logic is_self;
        r           = int'(row);
        c           = int'(col);
        on_row_edge = ((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= colums);
        on_col_edge = ((c == 0) || (c == colums + 1)) && (r >= 1) && (r <= rows);
        is_self     = (r == id_row) && (c == id_column);
        return (on_row_edge || on_col_edge) && !is_self;
    endfunction

endpackage

// File: rtl/mesh_tx_fifo.sv
// Packet buffer with a registered head output that holds its last value when empty.
// Latency: a push into an empty FIFO is on o_head the cycle after the edge.
// Backpressure: push refused when full unless a pop lands on the same edge (pop-through).
module mesh_tx_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_dat,
    output logic          o_push_ok,
    output logic          o_pop_ok,
    output logic [W-1:0]  o_head,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_head;

    logic          w_empty;
    logic          w_full;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic [AW-1:0] w_rd_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign w_rd_nxt  = r_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_nxt;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - (AW+1)'(1);
            end
            // Head is re-registered so the mesh sees a stable word, bypassing the array when the new head is being written now.
            if (w_empty && w_push_ok) begin
                r_head <= i_dat;
            end else if (w_pop_ok) begin
                if (r_count == (AW+1)'(1)) begin
                    if (w_push_ok) begin
                        r_head <= i_dat;
                    end
                end else begin
                    r_head <= r_mem[w_rd_nxt];
                end
            end
        end
    end

    assign o_push_ok = w_push_ok;
    assign o_pop_ok  = w_pop_ok;
    assign o_head    = r_head;
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

// File: rtl/mesh_term_tx.sv
// Mesh terminal transmit endpoint: assembles, checks and buffers packets, drives one mesh input port.
// Latency: accepted write is presented on data_out_i_in/pndng_i_in one cycle later when the buffer was empty.
// Backpressure: head held until popin; writes to a full buffer are dropped (ovf) unless popped same cycle.
// Optional build macro MESH_TX_SRC_STAMP_EN stamps the own terminal address into the top payload byte.
module mesh_term_tx
    import mesh_tx_pkg::*;
#(
    parameter int pckg_sz     = 40,
    parameter int fifo_depth  = 4,
    parameter int ROWS        = 4,
    parameter int COLUMS      = 4,
    parameter int id_row      = 0,
    parameter int id_column   = 0,
    parameter int STALL_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [3:0]           wr_row,
    input  logic [3:0]           wr_col,
    input  logic                 wr_mode,
    input  logic [pckg_sz-18:0]  wr_payload,
    output logic                 wr_ack,
    output logic [pckg_sz-1:0]   data_out_i_in,
    output logic                 pndng_i_in,
    input  logic                 popin,
    output logic                 full,
    output logic                 bad_dst,
    output logic                 ovf,
    output logic                 udf,
    output logic                 stall,
    output logic [15:0]          tx_count
);

    localparam int PW = pckg_sz - 17;
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = $clog2(STALL_LIMIT + 1);

    logic               w_legal;
    logic [PW-1:0]      w_payload;
    logic [pckg_sz-1:0] w_pkt;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [pckg_sz-1:0] w_head;
    logic [AW:0]        w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_drain;

    logic               r_wr_ack;
    logic               r_bad_dst;
    logic               r_ovf;
    logic               r_udf;
    logic [15:0]        r_tx_count;
    tx_wd_state_e       r_state;
    tx_wd_state_e       w_state_nxt;
    logic [CW-1:0]      r_wd_cnt;
    logic [CW-1:0]      w_wd_cnt_nxt;

    assign w_legal = is_legal_dst(wr_row, wr_col, ROWS, COLUMS, id_row, id_column);

`ifdef MESH_TX_SRC_STAMP_EN
    localparam logic [3:0] ID_R = 4'(id_row);
    localparam logic [3:0] ID_C = 4'(id_column);
    assign w_payload = {ID_R, ID_C, wr_payload[PW-9:0]};
`else
    assign w_payload = wr_payload;
`endif

    always_comb begin
        w_pkt                            = '0;
        w_pkt[pckg_sz-NXT_MSB -: 8]      = 8'h00;
        w_pkt[pckg_sz-ROW_MSB -: 4]      = wr_row;
        w_pkt[pckg_sz-COL_MSB -: 4]      = wr_col;
        w_pkt[pckg_sz-MODE_BIT]          = wr_mode;
        w_pkt[pckg_sz-PAYLOAD_MSB:0]     = w_payload;
    end

    mesh_tx_fifo #(
        .W     (pckg_sz),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (wr_en && w_legal),
        .i_pop     (popin),
        .i_dat     (w_pkt),
        .o_push_ok (w_push_ok),
        .o_pop_ok  (w_pop_ok),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ack   <= 1'b0;
            r_bad_dst  <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_tx_count <= '0;
        end else begin
            r_wr_ack  <= w_push_ok;
            r_bad_dst <= wr_en && !w_legal;
            if (wr_en && w_legal && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if (popin && w_empty) begin
                r_udf <= 1'b1;
            end
            if (w_pop_ok) begin
                r_tx_count <= r_tx_count + 16'd1;
            end
        end
    end

    // The last buffered packet leaves with nothing arriving to replace it.
    assign w_drain = w_pop_ok && !w_push_ok && (w_count == (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_wd_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wd_cnt <= w_wd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wd_cnt_nxt = r_wd_cnt;
        case (r_state)
            IDLE: begin
                if (w_push_ok) begin
                    w_state_nxt  = WAIT;
                    w_wd_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (w_pop_ok) begin
                    w_wd_cnt_nxt = '0;
                    if (w_drain) begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_wd_cnt == CW'(STALL_LIMIT - 1)) begin
                    w_state_nxt = STALLED;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + CW'(1);
                end
            end
            STALLED: begin
                if (w_pop_ok) begin
                    w_wd_cnt_nxt = '0;
                    w_state_nxt  = w_drain ? IDLE : WAIT;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_wd_cnt_nxt = '0;
            end
        endcase
    end

    assign wr_ack        = r_wr_ack;
    assign data_out_i_in = w_head;
    assign pndng_i_in    = !w_empty;
    assign full          = w_full;
    assign bad_dst       = r_bad_dst;
    assign ovf           = r_ovf;
    assign udf           = r_udf;
    assign stall         = (r_state == STALLED);
    assign tx_count      = r_tx_count;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Bench for mesh_term_tx: queue-based packet model checked every cycle, plus directed literal checks.
module tb_mesh_term_tx;

    localparam int PSZ   = 40;
    localparam int PW    = PSZ - 17;
    localparam int DEPTH = 4;
    localparam int LIMIT = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [3:0]     wr_row;
    logic [3:0]     wr_col;
    logic           wr_mode;
    logic [PW-1:0]  wr_payload;
    logic           popin;
    logic           wr_ack;
    logic [PSZ-1:0] data_out_i_in;
    logic           pndng_i_in;
    logic           full;
    logic           bad_dst;
    logic           ovf;
    logic           udf;
    logic           stall;
    logic [15:0]    tx_count;

    mesh_term_tx #(
        .pckg_sz     (PSZ),
        .fifo_depth  (DEPTH),
        .ROWS        (4),
        .COLUMS      (4),
        .id_row      (0),
        .id_column   (0),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_col        (wr_col),
        .wr_mode       (wr_mode),
        .wr_payload    (wr_payload),
        .wr_ack        (wr_ack),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .full          (full),
        .bad_dst       (bad_dst),
        .ovf           (ovf),
        .udf           (udf),
        .stall         (stall),
        .tx_count      (tx_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [PSZ-1:0] q[$];
    logic [PSZ-1:0] m_dout;
    bit             m_ack;
    bit             m_bad;
    bit             m_ovf;
    bit             m_udf;
    logic [15:0]    m_txc;
    int             m_age;
    bit             m_valid = 1'b0;

    // Border-ring terminals of a 4x4 mesh, excluding our own address (0,0).
    function automatic bit ref_legal(input int r, input int c);
        bit ok;
        ok = ((r == 0 || r == 5) && c >= 1 && c <= 4) ||
             ((c == 0 || c == 5) && r >= 1 && r <= 4);
        return ok && !(r == 0 && c == 0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        if (m_valid) begin
            chk("wr_ack",   64'(wr_ack),        64'(m_ack));
            chk("bad_dst",  64'(bad_dst),       64'(m_bad));
            chk("ovf",      64'(ovf),           64'(m_ovf));
            chk("udf",      64'(udf),           64'(m_udf));
            chk("tx_count", 64'(tx_count),      64'(m_txc));
            chk("pndng",    64'(pndng_i_in),    64'(q.size() != 0));
            chk("data_out", 64'(data_out_i_in), 64'(m_dout));
            chk("full",     64'(full),          64'(q.size() == DEPTH));
            chk("stall",    64'(stall),         64'(q.size() != 0 && m_age >= LIMIT));
        end
    endtask

    task automatic step(input bit rst, input bit we, input logic [3:0] r, input logic [3:0] c,
                        input bit m, input logic [PW-1:0] pl, input bit pp);
        bit             ne;
        bit             pop;
        bit             lg;
        bit             acc;
        logic [PSZ-1:0] pkt;
        @(negedge clk);
        check_model();
        reset      = rst;
        wr_en      = we;
        wr_row     = r;
        wr_col     = c;
        wr_mode    = m;
        wr_payload = pl;
        popin      = pp;
        if (!rst) begin
            q.delete();
            m_dout  = '0;
            m_ack   = 1'b0;
            m_bad   = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_txc   = '0;
            m_age   = 0;
            m_valid = 1'b1;
        end else begin
            ne  = (q.size() != 0);
            pop = pp && ne;
            if (pp && !ne) m_udf = 1'b1;
            lg  = we && ref_legal(int'(r), int'(c));
            acc = lg && (q.size() < DEPTH || pop);
            if (lg && !acc) m_ovf = 1'b1;
            m_ack = acc;
            m_bad = we && !ref_legal(int'(r), int'(c));
            pkt = {8'h00, r, c, m, pl};
`ifdef MESH_TX_SRC_STAMP_EN
            pkt[PW-1 -: 8] = 8'h00;
`endif
            if (!ne || pop) m_age = 0;
            else            m_age++;
            if (pop) begin
                void'(q.pop_front());
                m_txc++;
            end
            if (acc) q.push_back(pkt);
            if (q.size() != 0) m_dout = q[0];
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] r, input logic [3:0] c, input bit m, input logic [PW-1:0] pl);
        step(1'b1, 1'b1, r, c, m, pl, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        bit            r_rst;
        bit            r_we;
        bit            r_m;
        bit            r_pp;
        logic [3:0]    r_r;
        logic [3:0]    r_c;
        logic [PW-1:0] r_pl;
        int            pprob;

        reset = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0;
        wr_mode = 1'b0; wr_payload = '0; popin = 1'b0;

        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0);
        idle();
        chk("rst_pndng",    64'(pndng_i_in),    64'd0);
        chk("rst_data",     64'(data_out_i_in), 64'd0);
        chk("rst_tx_count", 64'(tx_count),      64'd0);
        chk("rst_full",     64'(full),          64'd0);
        chk("rst_stall",    64'(stall),         64'd0);

        wr(4'd0, 4'd2, 1'b1, 23'h5A);
        idle();
        chk("first_ack",   64'(wr_ack),        64'd1);
        chk("first_pndng", 64'(pndng_i_in),    64'd1);
        chk("first_data",  64'(data_out_i_in), 64'h00_0280_005A);
        pop_one();
        idle();
        chk("first_pop_pndng", 64'(pndng_i_in), 64'd0);
        chk("first_pop_txc",   64'(tx_count),   64'd1);

        wr(4'd2, 4'd2, 1'b0, 23'h123);
        idle();
        chk("interior_bad",   64'(bad_dst),    64'd1);
        chk("interior_pndng", 64'(pndng_i_in), 64'd0);
        idle();
        chk("bad_pulse_end",  64'(bad_dst),    64'd0);

        wr(4'd0, 4'd1, 1'b0, 23'd1);
        wr(4'd0, 4'd2, 1'b0, 23'd2);
        wr(4'd0, 4'd3, 1'b0, 23'd3);
        wr(4'd0, 4'd4, 1'b0, 23'd4);
        wr(4'd5, 4'd1, 1'b1, 23'd5);
        idle();
        chk("ovf_set",  64'(ovf),    64'd1);
        chk("ovf_ack",  64'(wr_ack), 64'd0);
        chk("ovf_full", 64'(full),   64'd1);
        step(1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 23'h77, 1'b1);
        idle();
        chk("popthru_ack",  64'(wr_ack),        64'd1);
        chk("popthru_full", 64'(full),          64'd1);
        chk("popthru_txc",  64'(tx_count),      64'd2);
        chk("popthru_head", 64'(data_out_i_in), 64'h00_0200_0002);
        repeat (4) pop_one();
        idle();
        chk("drain_pndng", 64'(pndng_i_in), 64'd0);

        pop_one();
        idle();
        chk("udf_set", 64'(udf),      64'd1);
        chk("udf_txc", 64'(tx_count), 64'd6);
        repeat (5) idle();
        chk("udf_sticky", 64'(udf), 64'd1);

        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0);
        idle();
        chk("rst_udf", 64'(udf), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        wr(4'd5, 4'd2, 1'b0, 23'd9);
        repeat (64) idle();
        chk("stall_early", 64'(stall), 64'd0);
        idle();
        chk("stall_set", 64'(stall), 64'd1);
        pop_one();
        idle();
        chk("stall_clear", 64'(stall),      64'd0);
        chk("stall_empty", 64'(pndng_i_in), 64'd0);

        wr(4'd1, 4'd0, 1'b0, 23'd1);
        wr(4'd2, 4'd5, 1'b1, 23'd2);
        wr(4'd3, 4'd0, 1'b0, 23'd3);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0);
        idle();
        chk("midrst_pndng", 64'(pndng_i_in), 64'd0);
        chk("midrst_txc",   64'(tx_count),   64'd0);
        chk("midrst_full",  64'(full),       64'd0);
        wr(4'd0, 4'd3, 1'b1, 23'd1);
        idle();
        chk("post_rst_pndng", 64'(pndng_i_in),    64'd1);
        chk("post_rst_data",  64'(data_out_i_in), 64'h00_0380_0001);

        for (int ph = 0; ph < 15; ph++) begin
            pprob = (ph % 3 == 0) ? 0 : ((ph % 3 == 1) ? 5 : 50);
            for (int i = 0; i < 200; i++) begin
                r_rst = ($urandom_range(0, 499) != 0);
                r_we  = 1'($urandom_range(0, 1));
                r_m   = 1'($urandom_range(0, 1));
                r_pp  = ($urandom_range(0, 99) < pprob);
                r_pl  = PW'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    r_r = 4'($urandom);
                    r_c = 4'($urandom);
                end else begin
                    r_r = 4'($urandom_range(0, 5));
                    r_c = 4'($urandom_range(0, 5));
                end
                step(r_rst, r_we, r_r, r_c, r_m, r_pl, r_pp);
            end
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
